// File: rtl/bist_march_sequencer_pkg.sv
// rtl/bist_march_sequencer_pkg.sv - shared types and March C- tables for the SRAM BIST datapath
//
// Purpose : state encoding, per-element direction/op table and op-count
//           constant used by bist_march_sequencer and bist_resp_compare.
// Ports   : none (package).
package bist_march_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_M0    = 4'd1,
      ST_M1    = 4'd2,
      ST_M2    = 4'd3,
      ST_M3    = 4'd4,
      ST_M4    = 4'd5,
      ST_M5    = 4'd6,
      ST_DRAIN = 4'd7,
      ST_DONE  = 4'd8
   } state_t;

   localparam int NO_OF_MARCH_STATES = 6;

   // Total ops per address summed over all six elements (1+2+2+2+2+1).
   localparam int MARCH_OPS_PER_ADDR = 10;

   typedef struct packed {
      logic is_read;   // 1 = read, 0 = write
      logic pol;       // data polarity: 1 = all-1s, 0 = all-0s
   } march_op_t;

   typedef struct packed {
      logic      desc;     // 1 = address max->0
      logic      two_ops;  // element issues op0 then op1 per address
      march_op_t op0;
      march_op_t op1;
   } march_elem_t;

   function automatic int march_op_count(input int addr_w);
      return MARCH_OPS_PER_ADDR * (2 ** addr_w);
   endfunction

   localparam int MARCH_OP_COUNT = march_op_count(8);

   // Index 6 and above return an ascending, empty element; the sequencer
   // uses that to reload the address to 0 when leaving M5.
   function automatic march_elem_t march_elem(input logic [2:0] idx);
      march_elem_t e;
      e = '0;
      case (idx)
         3'd0: e = '{desc: 1'b0, two_ops: 1'b0, op0: '{1'b0, 1'b0}, op1: '{1'b0, 1'b0}};
         3'd1: e = '{desc: 1'b0, two_ops: 1'b1, op0: '{1'b1, 1'b0}, op1: '{1'b0, 1'b1}};
         3'd2: e = '{desc: 1'b0, two_ops: 1'b1, op0: '{1'b1, 1'b1}, op1: '{1'b0, 1'b0}};
         3'd3: e = '{desc: 1'b1, two_ops: 1'b1, op0: '{1'b1, 1'b0}, op1: '{1'b0, 1'b1}};
         3'd4: e = '{desc: 1'b1, two_ops: 1'b1, op0: '{1'b1, 1'b1}, op1: '{1'b0, 1'b0}};
         3'd5: e = '{desc: 1'b0, two_ops: 1'b0, op0: '{1'b1, 1'b0}, op1: '{1'b0, 1'b0}};
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic logic [2:0] state_elem(input state_t s);
      logic [2:0] idx;
      idx = 3'd0;
      case (s)
         ST_M1:   idx = 3'd1;
         ST_M2:   idx = 3'd2;
         ST_M3:   idx = 3'd3;
         ST_M4:   idx = 3'd4;
         ST_M5:   idx = 3'd5;
         default: idx = 3'd0;
      endcase
      return idx;
   endfunction

   function automatic state_t next_elem_state(input state_t s);
      state_t n;
      n = s;
      case (s)
         ST_M0:   n = ST_M1;
         ST_M1:   n = ST_M2;
         ST_M2:   n = ST_M3;
         ST_M3:   n = ST_M4;
         ST_M4:   n = ST_M5;
         ST_M5:   n = ST_DRAIN;
         default: n = s;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bist_resp_compare.sv
// rtl/bist_resp_compare.sv - registered read-compare stage with sticky fail flag
//
// Purpose : captures the expected value of each issued read, compares it
//           against rdata one cycle later and latches a sticky fail.
//           With BIST_FAIL_LOG_EN defined, the first mismatch's address,
//           element and expected value are also held.
// Ports   : clk, rst (async active-low)
//           rd_en, rd_pol        - read issued this cycle and its polarity
//           rd_addr, rd_elem     - (BIST_FAIL_LOG_EN) address/element of the read
//           rdata                - SRAM read data, valid the cycle after rd_en
//           fail                 - sticky mismatch flag
//           fail_addr/elem/exp   - (BIST_FAIL_LOG_EN) first-mismatch log
module bist_resp_compare
   import bist_march_sequencer_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic              rd_pol,
`ifdef BIST_FAIL_LOG_EN
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [2:0]        rd_elem,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [DATA_W-1:0] fail_exp,
`endif
   input  logic [DATA_W-1:0] rdata,
   output logic              fail
);

   logic              vld_q;
   logic [DATA_W-1:0] exp_q;
   logic              mismatch;

   assign mismatch = vld_q && (rdata != exp_q);

   // The stage runs independently of cen so a read already issued still
   // gets checked while the sequencer is frozen or draining.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= 1'b0;
         exp_q <= '0;
         fail  <= 1'b0;
      end else begin
         vld_q <= rd_en;
         if (rd_en) begin
            exp_q <= rd_pol ? '1 : '0;
         end
         if (mismatch) begin
            fail <= 1'b1;
         end
      end
   end

`ifdef BIST_FAIL_LOG_EN
   logic [ADDR_W-1:0] cmp_addr_q;
   logic [2:0]        cmp_elem_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmp_addr_q <= '0;
         cmp_elem_q <= '0;
         fail_addr  <= '0;
         fail_elem  <= '0;
         fail_exp   <= '0;
      end else begin
         if (rd_en) begin
            cmp_addr_q <= rd_addr;
            cmp_elem_q <= rd_elem;
         end
         // fail is still low only on the very first mismatch.
         if (mismatch && !fail) begin
            fail_addr <= cmp_addr_q;
            fail_elem <= cmp_elem_q;
            fail_exp  <= exp_q;
         end
      end
   end
`endif

endmodule

// File: rtl/bist_march_sequencer.sv
// rtl/bist_march_sequencer.sv - March C- sequencer for the SRAM BIST datapath
//
// Purpose : while cen is high, walks March C- (M0..M5) over the SRAM,
//           issuing one op per cycle, then drains the compare stage and
//           raises cout. Optional first-fail log: BIST_FAIL_LOG_EN.
// Ports   : clk, rst (async active-low), cen (run enable)
//           rdata  - SRAM read data, valid one cycle after re
//           addr, wdata, we, re - SRAM access
//           cout   - test complete (held in DONE)
//           fail   - sticky mismatch
//           fail_addr/fail_elem/fail_exp - (BIST_FAIL_LOG_EN) first mismatch
module bist_march_sequencer
   import bist_march_sequencer_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   input  logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              we,
   output logic              re,
   output logic              cout,
`ifdef BIST_FAIL_LOG_EN
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [DATA_W-1:0] fail_exp,
`endif
   output logic              fail
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              op_q, op_d;

   logic              in_march;
   logic [2:0]        elem;
   march_elem_t       cur, nxt;
   march_op_t         op;
   logic              issue;
   logic              last_op;
   logic              last_addr;

   assign in_march  = (state_q >= ST_M0) && (state_q <= ST_M5);
   assign elem      = state_elem(state_q);
   assign cur       = march_elem(elem);
   assign nxt       = march_elem(3'(elem + 3'd1));
   assign op        = op_q ? cur.op1 : cur.op0;
   assign issue     = in_march && cen;
   assign last_op   = !cur.two_ops || op_q;
   assign last_addr = cur.desc ? (addr_q == '0) : (addr_q == ADDR_MAX);

   assign we    = issue && !op.is_read;
   assign re    = issue && op.is_read;
   assign wdata = (we && op.pol) ? '1 : '0;
   assign addr  = addr_q;
   assign cout  = (state_q == ST_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE: begin
            if (cen) begin
               state_d = ST_M0;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_DONE;
         default: begin
            // M0..M5: everything holds while cen is low.
            if (issue) begin
               if (!last_op) begin
                  op_d = 1'b1;
               end else begin
                  op_d = 1'b0;
                  if (last_addr) begin
                     // No bubble: the reload makes the next element's
                     // first address current on the very next cycle.
                     state_d = next_elem_state(state_q);
                     addr_d  = nxt.desc ? ADDR_MAX : '0;
                  end else begin
                     addr_d = cur.desc ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                  end
               end
            end
         end
      endcase
   end

   bist_resp_compare #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmp (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (re),
      .rd_pol    (op.pol),
`ifdef BIST_FAIL_LOG_EN
      .rd_addr   (addr_q),
      .rd_elem   (elem),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem),
      .fail_exp  (fail_exp),
`endif
      .rdata     (rdata),
      .fail      (fail)
   );

endmodule
